// File: rtl/uart_ram_loader_pkg.sv
// Shared definitions for the serial RAM boot loader.
//   loader_state_e : frame-parsing FSM states
//   SYNC_BYTE      : first byte of every image frame
//   calc_div       : clock cycles per UART bit for a given clock and baud rate
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } loader_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_ram_loader_if.sv
// RAM write port driven by the boot loader.
//   ram_we    : byte-lane write enables, lane k = ram_wdata[8k+7:8k]
//   ram_addr  : word address
//   ram_wdata : write data
// master = loader side, slave = RAM side.
interface uart_ram_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  modport master (output ram_we, output ram_addr, output ram_wdata);
  modport slave  (input  ram_we, input  ram_addr, input  ram_wdata);
endinterface

// File: rtl/uart_ram_loader_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst  : clock, asynchronous active-high reset
//   rxd       : raw serial input (idle high, LSB first)
//   rx_valid  : one-cycle strobe, good byte received (stop bit = 1)
//   rx_data   : received byte, valid with rx_valid
//   rx_ferr   : one-cycle strobe, stop bit sampled low
module uart_rx_byte #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             last_q,  last_d;
  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q,  data_d;
  logic             ferr_q,  ferr_d;

  // bit_q: 0 = waiting for start-bit centre, 1..8 = data bits, 9 = stop bit
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    last_d  = sync2_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ferr_d  = 1'b0;

    if (!busy_q) begin
      if (last_q && !sync2_q) begin
        busy_d = 1'b1;
        cnt_d  = '0;
        bit_d  = '0;
      end
    end else if (bit_q == 4'd0) begin
      if (cnt_q == HALF_LAST) begin
        // A start bit that is high again at its centre was a glitch.
        if (sync2_q) begin
          busy_d = 1'b0;
        end else begin
          cnt_d = '0;
          bit_d = 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q == BIT_LAST) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        // Back to idle at stop-bit centre so a back-to-back start edge is seen.
        busy_d = 1'b0;
        if (sync2_q) begin
          valid_d = 1'b1;
          data_d  = shift_q;
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        shift_d = {sync2_q, shift_q[7:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = data_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Serial boot loader: receives a framed image on the UART pin and writes it
// word by word into on-chip RAM, holding the CPU in reset until a complete,
// checksum-valid image has been written.
//   io_axiClk     : clock
//   io_asyncReset : asynchronous active-high reset
//   io_uart_rxd   : serial input, 8N1, idle high
//   ram           : RAM write port (ram_we / ram_addr / ram_wdata)
//   cpu_reset     : CPU reset request, released once the image is accepted
//   load_done     : sticky, image accepted
//   load_err      : sticky until next sync byte, frame rejected
// Frame: A5, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CSUM.
module uart_ram_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic               io_axiClk,
  input  logic               io_asyncReset,
  input  logic               io_uart_rxd,
  uart_ram_loader_if.master  ram,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_err
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk      (io_axiClk),
    .rst      (io_asyncReset),
    .rxd      (io_uart_rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  loader_state_e     state_q,     state_d;
  logic [15:0]       len_q,       len_d;
  logic [15:0]       word_cnt_q,  word_cnt_d;
  logic [1:0]        byte_cnt_q,  byte_cnt_d;
  logic [7:0]        sum_q,       sum_d;
  logic [23:0]       word_q,      word_d;
  logic [3:0]        we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;

  logic [15:0] n_words;
  assign n_words = {rx_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    sum_d       = sum_q;
    word_d      = word_q;
    we_d        = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;

    if (rx_ferr && state_q != ST_DONE) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d    = ST_LEN_LO;
            err_d      = 1'b0;
            sum_d      = '0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
          end
        end
        ST_LEN_LO: begin
          len_d   = {8'h00, rx_data};
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d = n_words;
          if ({1'b0, n_words} > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (n_words == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          sum_d      = sum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              // Lane 3 completes the word; write it straight from the byte.
              we_d       = '1;
              addr_d     = word_cnt_q[ADDR_W-1:0];
              wdata_d    = {rx_data, word_q};
              word_cnt_d = word_cnt_q + 16'd1;
              if (word_cnt_q == len_q - 16'd1) begin
                state_d = ST_CSUM;
              end
            end
          endcase
        end
        ST_CSUM: begin
          if (rx_data == sum_q) begin
            state_d     = ST_DONE;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      sum_q       <= '0;
      word_q      <= '0;
      we_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      sum_q       <= sum_d;
      word_q      <= word_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: a table of UART bytes (plus glitch and
// asynchronous-reset entries), each with the loader status and RAM write
// expected once that byte has been fully received.
module tb_uart_ram_loader;

  localparam int unsigned CLK_FREQ = 1600;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned DIV      = 16;
  localparam int unsigned ADDR_W   = 14;

  localparam logic [1:0] K_BYTE   = 2'd0;
  localparam logic [1:0] K_GLITCH = 2'd1;
  localparam logic [1:0] K_ARST   = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic              rst_before;
    logic [7:0]        data;
    logic              stop;
    logic              exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
    logic              exp_cpu;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic cpu_reset, load_done, load_err;

  always #5 clk = ~clk;

  uart_ram_loader_if #(.ADDR_W(ADDR_W)) ram_bus ();

  uart_ram_loader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W)
  ) dut (
    .io_axiClk     (clk),
    .io_asyncReset (rst),
    .io_uart_rxd   (rxd),
    .ram           (ram_bus),
    .cpu_reset     (cpu_reset),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  // Write monitor: counts cycles with any lane enabled, keeps the last write.
  int                we_cycles = 0;
  logic [3:0]        last_we   = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_wdata = '0;

  always @(negedge clk) begin
    if (ram_bus.ram_we != 4'h0) begin
      we_cycles  <= we_cycles + 1;
      last_we    <= ram_bus.ram_we;
      last_addr  <= ram_bus.ram_addr;
      last_wdata <= ram_bus.ram_wdata;
    end
  end

  int vectors    = 0;
  int miscompares = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s [vec %0d] actual=%h required=%h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] kind, input logic rb, input logic [7:0] d,
                     input logic stop, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [31:0] wd, input logic cpu, input logic done,
                     input logic err);
    vec_t v;
    v.kind = kind; v.rst_before = rb; v.data = d; v.stop = stop;
    v.exp_wr = wr; v.exp_addr = a; v.exp_wdata = wd;
    v.exp_cpu = cpu; v.exp_done = done; v.exp_err = err;
    vecs.push_back(v);
  endtask

  // Shorthands: plain byte with resulting status, byte that completes a word.
  task automatic nb(input logic rb, input logic [7:0] d, input logic cpu,
                    input logic done, input logic err);
    add(K_BYTE, rb, d, 1'b1, 1'b0, '0, '0, cpu, done, err);
  endtask

  task automatic wb(input logic [7:0] d, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    add(K_BYTE, 1'b0, d, 1'b1, 1'b1, a, wd, 1'b1, 1'b0, 1'b0);
  endtask

  // Drives one 8N1 character; a low stop bit is followed by one idle bit so
  // the next start edge is visible.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (DIV) @(negedge clk);
  endtask

  task automatic glitch();
    rxd = 1'b0;
    repeat (6) @(negedge clk);   // 0.4 bit
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reset asserted between clock edges must clear outputs before any edge.
  task automatic async_reset_check(input int idx);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ram_we",    idx, 32'(ram_bus.ram_we),    32'h0);
    chk("arst_ram_addr",  idx, 32'(ram_bus.ram_addr),  32'h0);
    chk("arst_ram_wdata", idx, ram_bus.ram_wdata,      32'h0);
    chk("arst_cpu_reset", idx, 32'(cpu_reset),         32'h1);
    chk("arst_load_done", idx, 32'(load_done),         32'h0);
    chk("arst_load_err",  idx, 32'(load_err),          32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Good 2-word frame; data byte sum 0x44C -> CSUM 0x4C.
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h02, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h78, 1, 0, 0); nb(0, 8'h56, 1, 0, 0); nb(0, 8'h34, 1, 0, 0);
    wb(8'h12, 14'd0, 32'h12345678);
    nb(0, 8'hEF, 1, 0, 0); nb(0, 8'hBE, 1, 0, 0); nb(0, 8'hAD, 1, 0, 0);
    wb(8'hDE, 14'd1, 32'hDEADBEEF);
    nb(0, 8'h4C, 0, 1, 0);
    nb(0, 8'hA5, 0, 1, 0);                                  // ignored once done
    add(K_BYTE, 0, 8'h00, 1'b0, 0, '0, '0, 0, 1, 0);        // framing error ignored once done

    // Bad checksum, then the correct frame.
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h02, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h78, 1, 0, 0); nb(0, 8'h56, 1, 0, 0); nb(0, 8'h34, 1, 0, 0);
    wb(8'h12, 14'd0, 32'h12345678);
    nb(0, 8'hEF, 1, 0, 0); nb(0, 8'hBE, 1, 0, 0); nb(0, 8'hAD, 1, 0, 0);
    wb(8'hDE, 14'd1, 32'hDEADBEEF);
    nb(0, 8'h4D, 1, 0, 1);
    nb(0, 8'hA5, 1, 0, 0); nb(0, 8'h02, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h78, 1, 0, 0); nb(0, 8'h56, 1, 0, 0); nb(0, 8'h34, 1, 0, 0);
    wb(8'h12, 14'd0, 32'h12345678);
    nb(0, 8'hEF, 1, 0, 0); nb(0, 8'hBE, 1, 0, 0); nb(0, 8'hAD, 1, 0, 0);
    wb(8'hDE, 14'd1, 32'hDEADBEEF);
    nb(0, 8'h4C, 0, 1, 0);

    // Leading garbage, then a 1-word frame.
    nb(1, 8'h00, 1, 0, 0); nb(0, 8'hFF, 1, 0, 0); nb(0, 8'h13, 1, 0, 0);
    nb(0, 8'hA5, 1, 0, 0); nb(0, 8'h01, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h01, 1, 0, 0); nb(0, 8'h00, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    wb(8'h00, 14'd0, 32'h00000001);
    nb(0, 8'h01, 0, 1, 0);

    // Empty image.
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h00, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h00, 0, 1, 0);

    // Length boundary: 16384 words accepted, 16385 rejected.
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h00, 1, 0, 0); nb(0, 8'h40, 1, 0, 0);
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h01, 1, 0, 0); nb(0, 8'h40, 1, 0, 1);

    // Framing error on a data byte; FSM must be back in IDLE.
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h01, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    add(K_BYTE, 0, 8'h11, 1'b0, 0, '0, '0, 1, 0, 1);
    nb(0, 8'h22, 1, 0, 1);
    nb(0, 8'hA5, 1, 0, 0); nb(0, 8'h01, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h11, 1, 0, 0); nb(0, 8'h22, 1, 0, 0); nb(0, 8'h33, 1, 0, 0);
    wb(8'h44, 14'd0, 32'h44332211);
    nb(0, 8'hAA, 0, 1, 0);

    // Short low glitch after sync must not become a length byte.
    nb(1, 8'hA5, 1, 0, 0);
    add(K_GLITCH, 0, 8'h00, 1'b1, 0, '0, '0, 1, 0, 0);
    nb(0, 8'h01, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h11, 1, 0, 0); nb(0, 8'h22, 1, 0, 0); nb(0, 8'h33, 1, 0, 0);
    wb(8'h44, 14'd0, 32'h44332211);
    nb(0, 8'hAA, 0, 1, 0);

    // Asynchronous reset mid-frame, then a full reload.
    nb(1, 8'hA5, 1, 0, 0); nb(0, 8'h03, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h78, 1, 0, 0); nb(0, 8'h56, 1, 0, 0); nb(0, 8'h34, 1, 0, 0);
    wb(8'h12, 14'd0, 32'h12345678);
    nb(0, 8'hEF, 1, 0, 0); nb(0, 8'hBE, 1, 0, 0); nb(0, 8'hAD, 1, 0, 0);
    wb(8'hDE, 14'd1, 32'hDEADBEEF);
    nb(0, 8'h11, 1, 0, 0); nb(0, 8'h22, 1, 0, 0);
    add(K_ARST, 0, 8'h00, 1'b1, 0, '0, '0, 1, 0, 0);
    nb(0, 8'hA5, 1, 0, 0); nb(0, 8'h01, 1, 0, 0); nb(0, 8'h00, 1, 0, 0);
    nb(0, 8'h11, 1, 0, 0); nb(0, 8'h22, 1, 0, 0); nb(0, 8'h33, 1, 0, 0);
    wb(8'h44, 14'd0, 32'h44332211);
    nb(0, 8'hAA, 0, 1, 0);

    // Reset values, held in reset and one cycle after release.
    repeat (3) @(negedge clk);
    vectors++;
    chk("rst_ram_we",    -1, 32'(ram_bus.ram_we),   32'h0);
    chk("rst_ram_addr",  -1, 32'(ram_bus.ram_addr), 32'h0);
    chk("rst_ram_wdata", -1, ram_bus.ram_wdata,     32'h0);
    chk("rst_cpu_reset", -1, 32'(cpu_reset),        32'h1);
    chk("rst_load_done", -1, 32'(load_done),        32'h0);
    chk("rst_load_err",  -1, 32'(load_err),         32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    chk("idle_cpu_reset", -1, 32'(cpu_reset), 32'h1);
    chk("idle_ram_we",    -1, 32'(ram_bus.ram_we), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      int   base;
      v = vecs[i];
      if (v.rst_before) pulse_reset();
      base = we_cycles;
      case (v.kind)
        K_GLITCH: glitch();
        K_ARST:   async_reset_check(i);
        default:  send_byte(v.data, v.stop);
      endcase
      vectors++;
      chk("cpu_reset", i, 32'(cpu_reset), 32'(v.exp_cpu));
      chk("load_done", i, 32'(load_done), 32'(v.exp_done));
      chk("load_err",  i, 32'(load_err),  32'(v.exp_err));
      chk("we_cycles", i, 32'(we_cycles - base), v.exp_wr ? 32'd1 : 32'd0);
      if (v.exp_wr) begin
        chk("ram_we",    i, 32'(last_we),   32'hF);
        chk("ram_addr",  i, 32'(last_addr), 32'(v.exp_addr));
        chk("ram_wdata", i, last_wdata,     v.exp_wdata);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
